// File: rtl/fifo_pkg.sv
// fifo_pkg: shared word type and default sizing for the FIFO read side.
package fifo_pkg;
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEEP = 8;
    localparam int FIFO_OUT_BUF_DEPTH = 4;
    typedef struct packed {
        logic [FIFO_WIDTH-1:0] data;
        logic [FIFO_DEEP:0]    addr;
    } fifo_word_t;
endpackage

// File: rtl/fifo_out_buf.sv
// fifo_out_buf: circular skid buffer with push/pop, full/empty and occupancy count.
module fifo_out_buf #(
    parameter int DW = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr, rd;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    // a push into a full buffer lands only when the head slot is freed in the same cycle
    assign wr = push && (!full || pop);
    assign rd = pop && !empty;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= wdata;
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/fifo_rd_out.sv
// fifo_rd_out: FIFO read-side output stage with credit-based request and valid/ready output.
// Defining FIFO_RD_OUT_STATS_EN adds a saturating 16-bit handshake counter port xfer_cnt.
module fifo_rd_out
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEEP = FIFO_DEEP,
    parameter int BUF_DEPTH = FIFO_OUT_BUF_DEPTH
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             pop,
    input  logic [DEEP:0]    rd_addr,
    input  logic [WIDTH-1:0] mem_data,
    output logic             en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [DEEP:0]    out_addr,
`ifdef FIFO_RD_OUT_STATS_EN
    output logic             ovf,
    output logic [15:0]      xfer_cnt
`else
    output logic             ovf
`endif
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    logic pop_q, en_q, full, empty, rd;
    logic [DEEP:0] addr_q;
    logic [CW-1:0] count;
    fifo_out_buf #(.DW(WIDTH + DEEP + 1), .DEPTH(BUF_DEPTH)) u_buf (
        .clk(clk),
        .arst(arst),
        .push(pop_q),
        .pop(rd),
        .wdata({mem_data, addr_q}),
        .rdata({out_data, out_addr}),
        .count(count),
        .full(full),
        .empty(empty)
    );
    assign out_valid = !empty;
    assign rd = out_valid && out_ready;
    // outstanding requests and in-flight data each hold a slot, so nothing requested can be dropped
    assign en = !arst && ((CW+1)'(count) + (CW+1)'(en_q) + (CW+1)'(pop_q) < (CW+1)'(BUF_DEPTH));
    always_ff @(posedge clk) begin
        if (arst) begin
            pop_q <= 1'b0;
            en_q <= 1'b0;
            addr_q <= '0;
            ovf <= 1'b0;
        end else begin
            pop_q <= pop;
            en_q <= en;
            if (pop) addr_q <= rd_addr;
            if (pop_q && full && !rd) ovf <= 1'b1;
        end
    end
`ifdef FIFO_RD_OUT_STATS_EN
    always_ff @(posedge clk) begin
        if (arst) xfer_cnt <= '0;
        else if (rd && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fifo_rd_out.sv
// tb_fifo_rd_out: directed stimulus against a queue-based model of the output stage.
module tb_fifo_rd_out;
    import fifo_pkg::*;
    logic clk = 1'b0, arst = 1'b1, pop = 1'b1, out_ready = 1'b0;
    logic [8:0] rd_addr = '0;
    logic [7:0] mem_data = 8'hAA;
    logic en, out_valid, ovf;
    logic [7:0] out_data;
    logic [8:0] out_addr;
`ifdef FIFO_RD_OUT_STATS_EN
    logic [15:0] xfer_cnt;
`endif
    int checks = 0, errors = 0;
    fifo_word_t mq[$];
    logic m_popq = 1'b0, m_enq = 1'b0, m_ovf = 1'b0;
    logic [8:0] m_addr = '0;
    logic [7:0] recv[$];
    logic e_s = 1'b0, chk_en = 1'b0;
    int cyc = 0, first_v = 0, en_low = 0;

    always #5 clk = ~clk;

    fifo_rd_out dut (
        .clk(clk),
        .arst(arst),
        .pop(pop),
        .rd_addr(rd_addr),
        .mem_data(mem_data),
        .en(en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_addr(out_addr),
`ifdef FIFO_RD_OUT_STATS_EN
        .ovf(ovf),
        .xfer_cnt(xfer_cnt)
`else
        .ovf(ovf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_en();
        return !arst && (mq.size() + int'(m_enq) + int'(m_popq) < FIFO_OUT_BUF_DEPTH);
    endfunction

    task automatic model_step();
        bit rd, full, en_now;
        en_now = m_en();
        if (arst) begin
            mq.delete();
            m_popq = 1'b0;
            m_enq = 1'b0;
            m_ovf = 1'b0;
            m_addr = '0;
        end else begin
            rd = mq.size() != 0 && out_ready;
            full = mq.size() == FIFO_OUT_BUF_DEPTH;
            if (m_popq && full && !rd) m_ovf = 1'b1;
            if (rd) void'(mq.pop_front());
            if (m_popq && (!full || rd)) mq.push_back('{data: mem_data, addr: m_addr});
            m_enq = en_now;
            m_popq = pop;
            if (pop) m_addr = rd_addr;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            chk("en", en, m_en());
            chk("out_valid", out_valid, mq.size() != 0);
            chk("ovf", ovf, m_ovf);
            if (mq.size() != 0) begin
                chk("out_data", out_data, mq[0].data);
                chk("out_addr", out_addr, mq[0].addr);
            end
        end
        e_s = en;
        if (!en) en_low++;
        if (out_valid && first_v == 0) first_v = cyc;
        if (out_valid && out_ready) recv.push_back(out_data);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit p, input int lim);
        mem_data = 8'h10 + rd_addr[7:0];
        if (pop) rd_addr = rd_addr + 9'd1;
        pop = p && (rd_addr < lim);
    endtask

    // mode 0 honours en, 1 forces pop, 2 holds pop low
    task automatic run(input int n, input int mode, input int lim);
        repeat (n) begin
            tick();
            drive((mode == 1) || (mode == 0 && e_s), lim);
        end
    endtask

    task automatic release_rst();
        arst = 1'b0;
        pop = 1'b0;
        rd_addr = '0;
        mem_data = '0;
        cyc = 0;
        first_v = 0;
        en_low = 0;
        recv.delete();
    endtask

    task automatic do_reset(input int n);
        arst = 1'b1;
        pop = 1'b0;
        repeat (n) tick();
        release_rst();
    endtask

    task automatic chk_order(input string name);
        for (int i = 0; i < recv.size(); i++) chk(name, recv[i], 8'h10 + i);
    endtask

    initial begin
        // reset held with pop and junk data present
        tick();
        chk_en = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_valid", out_valid, 0);
            chk("rst_en", en, 0);
            chk("rst_ovf", ovf, 0);
        end
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);
        release_rst();
        #1;
        chk("en_after_release", en, 1);

        // streaming with consumer always ready
        out_ready = 1'b1;
        run(14, 0, 8);
        chk("first_valid_cycle", first_v, 4);
        chk("stream_n", recv.size(), 8);
        chk_order("stream_order");
        chk("stream_en_low", en_low, 0);

        // stalled consumer fills exactly four credits
        out_ready = 1'b0;
        do_reset(2);
        run(10, 0, 100);
        chk("stall_valid", out_valid, 1);
        chk("stall_head", out_data, 8'h10);
        chk("stall_en", en, 0);
        chk("stall_ovf", ovf, 0);
        chk("stall_pops", rd_addr, 4);

        // release the stall and keep streaming
        out_ready = 1'b1;
        run(16, 0, 100);
        chk("drain_n_ge8", recv.size() >= 8, 1);
        chk_order("drain_order");

        // protocol violation: six pops into a stalled four-entry buffer
        out_ready = 1'b0;
        do_reset(2);
        run(6, 1, 100);
        run(4, 2, 100);
        chk("ovf_set", ovf, 1);
        chk("ovf_head", out_data, 8'h10);
        out_ready = 1'b1;
        run(6, 2, 100);
        chk("ovf_kept_n", recv.size(), 4);
        chk_order("ovf_kept_order");
        chk("ovf_empty", out_valid, 0);
        chk("ovf_sticky", ovf, 1);

`ifdef FIFO_RD_OUT_STATS_EN
        do_reset(2);
        out_ready = 1'b1;
        run(70010, 0, 1 << 20);
        chk("xfer_sat", xfer_cnt, 16'hFFFF);
        arst = 1'b1;
        tick();
        chk("xfer_rst", xfer_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_rd_out.md
# fifo_rd_out

Downstream output stage of the FIFO read side. It takes the read controller's `pop` strobe and the one-cycle-latency memory read data, and holds the words in a small skid buffer. It presents them to the consumer on a valid/ready stream. It also drives the read controller's `en` input as a credit-based request, so words already requested are never dropped. Sits between the FIFO memory/read controller and the consuming logic.

## Interface
- `WIDTH`, 8, data word width.
- `DEEP`, 8, memory depth parameter, matching the read controller; address width is `DEEP+1`.
- `BUF_DEPTH`, 4, skid buffer entries; legal values 3..8.

- `clk` in 1: single clock, rising edge.
- `arst` in 1: reset, **synchronous, active-high**.
- `pop` in 1: read strobe from the read controller; memory data for it is valid exactly 1 cycle later.
- `rd_addr` in DEEP+1: read controller address; registered alongside data for debug.
- `mem_data` in WIDTH: memory read data.
- `en` out 1: request to the read controller; the controller may assert `pop` in the following cycle.
- `out_valid` out 1: head word available.
- `out_ready` in 1: consumer accepts the head word.
- `out_data` out WIDTH: head word.
- `out_addr` out DEEP+1: memory address the head word came from.
- `ovf` out 1: sticky error, set when data arrived into a full buffer.

## Operation
- Internal state:
  - `pop_q`: `pop` delayed 1 cycle; marks `mem_data` valid.
  - `en_q`: `en` delayed 1 cycle; a reserved credit.
  - `count`: 0..BUF_DEPTH.
  - Circular buffer with `wr_ptr` and `rd_ptr`.
- Write: when `pop_q`=1, store {`mem_data`, address latched with `pop`} at `wr_ptr`; `wr_ptr` increments modulo BUF_DEPTH.
- Read: when `out_valid && out_ready`, `rd_ptr` increments modulo BUF_DEPTH.
- `count` update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged when both occur in the same cycle, including at `count`=BUF_DEPTH when a read frees the slot.
- `out_valid` = (`count` != 0).
- `out_data` and `out_addr` come from the entry at `rd_ptr`.
- `en` = (`count` + `en_q` + `pop_q`) < BUF_DEPTH and not `arst`.
  - Registered-input only; no combinational path from `out_ready`.
  - Credits are conservative: `en_q` is counted even if the controller does not pop (e.g. FIFO empty).
- Overflow: write with `count`=BUF_DEPTH and no simultaneous read sets `ovf`.
  - The word is discarded; pointers and `count` are unchanged.
  - `ovf` clears only on reset.
- Steady state with `out_ready`=1: `count`=1, `en_q`=1, `pop_q`=1, so `en` stays 1, giving one word per cycle.

## Timing
- Reset values: `count`=0, pointers 0, `pop_q`=0, `en_q`=0, `ovf`=0, `out_valid`=0, `en`=0.
  - `out_data` and `out_addr` are 0 from the cleared entry 0.
- First `en`=1 is in the cycle after reset deasserts.
- Latency: `en`=1 at N → `pop` at N+1 → write at the N+2 edge → `out_valid` at N+3.
- Consumer contract: `out_data` and `out_addr` are stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-operation: all in-flight `pop_q` data and buffered words are discarded; nothing is presented after reset until a new `pop`.
- `pop` while `en` was 0 in the previous cycle is a protocol error.
  - The word is still accepted if space exists.
  - Otherwise `ovf` is set.

## Configuration
- `FIFO_RD_OUT_STATS_EN` defined: adds output port `xfer_cnt` (16 bit).
  - Counts accepted handshakes.
  - Saturates at 0xFFFF.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `fifo_pkg`:
  - `fifo_word_t` (WIDTH data + DEEP+1 address).
  - Default constants `FIFO_WIDTH`=8, `FIFO_DEEP`=8, `FIFO_OUT_BUF_DEPTH`=4.
- One sub-module, `fifo_out_buf`:
  - Circular buffer, pointers and `count`, with push/pop/full/empty.
  - `fifo_rd_out` keeps the credit logic, `pop_q`/`en_q`, `ovf` and stats.

## Test plan
- Reset held 3 cycles with `pop`=1 and `mem_data`=0xAA → `out_valid`=0, `en`=0 and `ovf`=0 throughout; `en`=1 one cycle after release.
- Issue `pop` for addresses 0..7 with data 0x10..0x17, `out_ready`=1 → 8 words out in order, one per cycle after 3-cycle fill; `en` never drops.
- `out_ready`=0 while the controller honours `en` → exactly 4 words buffered (0x10..0x13); `en`=0 from the cycle credits reach 4; `ovf`=0.
- Same as the previous test, then `out_ready`=1 → words 0x10..0x13 drain; `en` reasserts; the next words resume with no gap or duplicate.
- Force `pop`=1 for 6 cycles while `out_ready`=0, ignoring `en` → `ovf`=1 after the 5th write arrives; buffer still holds the first 4 words.
- With `FIFO_RD_OUT_STATS_EN`, 70000 handshakes → `xfer_cnt`=0xFFFF; assert reset → `xfer_cnt`=0.
